// File: rtl/cpu_pkg.sv
// Encodings shared across the CPU core: result-source select, load funct3
// codes and the writeback FSM states.
package cpu_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_LOAD = 2'b01,
        WRITE     = 2'b10
    } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage handshake: retiring instruction and its
// result sources.
interface writeback_stage_if import cpu_pkg::*; #(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) ();
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic              in_reg_write;
    logic [1:0]        in_result_src;
    logic [2:0]        in_funct3;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_pc_plus4;

    modport master (
        output in_valid, in_rd, in_reg_write, in_result_src, in_funct3,
               in_alu_result, in_pc_plus4,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_reg_write, in_result_src, in_funct3,
               in_alu_result, in_pc_plus4,
        output in_ready
    );
endinterface

// File: rtl/load_extend.sv
// Combinational load-data alignment: picks the addressed byte/halfword out of
// a little-endian word and sign- or zero-extends it.
module load_extend import cpu_pkg::*; #(
    parameter int DATA_W = WB_DATA_W
) (
    input  logic [DATA_W-1:0] word,
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] data
);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = word[{offset, 3'b000} +: 8];
        // Halfwords are selected by offset[1] only; offset[0] is ignored.
        half_s = word[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   data = {{(DATA_W-8){byte_s[7]}}, byte_s};
            F3_LBU:  data = {{(DATA_W-8){1'b0}}, byte_s};
            F3_LH:   data = {{(DATA_W-16){half_s[15]}}, half_s};
            F3_LHU:  data = {{(DATA_W-16){1'b0}}, half_s};
            F3_LW:   data = word;
            default: data = word;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: sole writer of the register file, waits on load
// responses, and reports retired count and stray-response errors.
module writeback_stage import cpu_pkg::*; #(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  mi,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              rf_we3,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              rsp_err,
    output logic [31:0]       instret
);
    wb_state_t         state_q, state_d;
    logic              accept, no_write, is_load;
    logic [ADDR_W-1:0] wr_rd_d;
    logic [DATA_W-1:0] wr_data_d, ld_data;

    logic [ADDR_W-1:0] ld_rd_p0;
    logic [2:0]        ld_funct3_p0;
    logic [1:0]        ld_off_p0;

    logic              we_p1;
    logic [ADDR_W-1:0] a3_p1;
    logic [DATA_W-1:0] wd3_p1;
    logic              err_q;
    logic [31:0]       instret_q;

    assign mi.in_ready = (state_q != WAIT_LOAD);
    assign accept      = mi.in_valid && mi.in_ready;
    assign no_write    = !mi.in_reg_write || (mi.in_rd == '0);
    assign is_load     = (mi.in_result_src == RES_LOAD);

    load_extend #(.DATA_W(DATA_W)) u_ext (
        .word   (mem_rsp_data),
        .funct3 (ld_funct3_p0),
        .offset (ld_off_p0),
        .data   (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        wr_rd_d   = mi.in_rd;
        wr_data_d = (mi.in_result_src == RES_PC4) ? mi.in_pc_plus4 : mi.in_alu_result;
        case (state_q)
            WAIT_LOAD: begin
                wr_rd_d   = ld_rd_p0;
                wr_data_d = ld_data;
                if (mem_rsp_valid) state_d = WRITE;
            end
            default: begin
                if (!accept || no_write) state_d = IDLE;
                else if (is_load)        state_d = WAIT_LOAD;
                else                     state_d = WRITE;
            end
        endcase
    end

    // Stage p0: load context captured at accept, consumed when the response lands.
    always_ff @(posedge clk) begin
        if (accept) begin
            ld_rd_p0     <= mi.in_rd;
            ld_funct3_p0 <= mi.in_funct3;
            ld_off_p0    <= mi.in_alu_result[1:0];
        end
    end

    // Stage p1: registered write port, error flag and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            we_p1     <= 1'b0;
            a3_p1     <= '0;
            wd3_p1    <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            we_p1   <= (state_d == WRITE);
            if (state_d == WRITE) begin
                a3_p1  <= wr_rd_d;
                wd3_p1 <= wr_data_d;
            end
            if (mem_rsp_valid && (state_q != WAIT_LOAD)) err_q <= 1'b1;
            // Write-backs and no-write retires are mutually exclusive per cycle.
            if ((state_d == WRITE) || (accept && no_write)) instret_q <= instret_q + 32'd1;
        end
    end

    assign rf_we3    = we_p1;
    assign rf_a3     = a3_p1;
    assign rf_wd3    = wd3_p1;
    assign fwd_valid = we_p1;
    assign fwd_rd    = a3_p1;
    assign fwd_data  = wd3_p1;
    assign rsp_err   = err_q;
    assign instret   = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed sequences, a load-extension vector
// table and a randomized instruction stream against a reference model.
module tb_writeback_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        rf_we3;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        rsp_err;
    logic [31:0] instret;

    writeback_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .mi            (bus),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rf_a3         (rf_a3),
        .rf_wd3        (rf_wd3),
        .rf_we3        (rf_we3),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .rsp_err       (rsp_err),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid      = 1'b0;
        bus.in_rd         = '0;
        bus.in_reg_write  = 1'b0;
        bus.in_result_src = '0;
        bus.in_funct3     = '0;
        bus.in_alu_result = '0;
        bus.in_pc_plus4   = '0;
        mem_rsp_valid     = 1'b0;
        mem_rsp_data      = '0;
    endtask

    task automatic send(input logic [4:0] rd, input logic rw, input logic [1:0] src,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc);
        bus.in_valid      = 1'b1;
        bus.in_rd         = rd;
        bus.in_reg_write  = rw;
        bus.in_result_src = src;
        bus.in_funct3     = f3;
        bus.in_alu_result = alu;
        bus.in_pc_plus4   = pc;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Load extension worked out with shifts and arithmetic on the raw word.
    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] word;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    ld_vec_t     vecs [11];
    wr_t         expq [$];
    wr_t         w;
    int          exp_instret;
    int          low;
    int          issued, cyc, wait_c;
    logic        pend;
    logic [4:0]  prd, r_rd;
    logic [2:0]  pf3, r_f3;
    logic [1:0]  poff, r_src;
    logic        r_rw;
    logic [31:0] r_alu, r_pc, r_word, tmp;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
        vecs[1]  = '{3'b100, 2'd3, 32'h80FF7F01, 32'h00000080};
        vecs[2]  = '{3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[3]  = '{3'b101, 2'd2, 32'h80FF7F01, 32'h000080FF};
        vecs[4]  = '{3'b010, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
        vecs[5]  = '{3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F};
        vecs[6]  = '{3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[7]  = '{3'b011, 2'd2, 32'h80FF7F01, 32'h80FF7F01};
        vecs[8]  = '{3'b100, 2'd0, 32'h80FF7F01, 32'h00000001};
        vecs[9]  = '{3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01};
        vecs[10] = '{3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};

        // Reset state
        rst = 1'b0;
        idle();
        step();
        step();
        chk("rst_we3", 32'(rf_we3), 32'd0);
        chk("rst_a3", 32'(rf_a3), 32'd0);
        chk("rst_wd3", rf_wd3, 32'd0);
        chk("rst_fwd", {fwd_data[29:0], fwd_valid, |fwd_rd}, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;
        step();

        // Reset while a load is pending, then a stray response
        send(5'd5, 1'b1, 2'b01, 3'b010, 32'h0, 32'h0);
        step();
        idle();
        chk("A_ready_wait", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("A_ready_rst", 32'(bus.in_ready), 32'd1);
        step();
        rst = 1'b1;
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h12345678;
        step();
        idle();
        chk("A_err", 32'(rsp_err), 32'd1);
        chk("A_we0", 32'(rf_we3), 32'd0);
        step();
        chk("A_we1", 32'(rf_we3), 32'd0);
        chk("A_instret", instret, 32'd0);

        // Back-to-back ALU then PC+4
        do_reset();
        exp_instret = 0;
        send(5'd9, 1'b1, 2'b00, 3'b000, 32'h00000020, 32'h11110000);
        step();
        send(5'd1, 1'b1, 2'b10, 3'b000, 32'hCAFE0000, 32'h00000104);
        chk("B_we_a", 32'(rf_we3), 32'd1);
        chk("B_a3_a", 32'(rf_a3), 32'd9);
        chk("B_wd3_a", rf_wd3, 32'h20);
        chk("B_fwd_a", {fwd_valid, 26'd0, fwd_rd}, {1'b1, 26'd0, 5'd9});
        chk("B_fwdd_a", fwd_data, 32'h20);
        step();
        idle();
        chk("B_we_b", 32'(rf_we3), 32'd1);
        chk("B_a3_b", 32'(rf_a3), 32'd1);
        chk("B_wd3_b", rf_wd3, 32'h104);
        step();
        chk("B_we_c", 32'(rf_we3), 32'd0);
        chk("B_instret", instret, 32'd2);
        exp_instret = 2;

        // Load extension table, response after three idle cycles
        for (int i = 0; i < 11; i++) begin
            tmp = ($urandom() & 32'hFFFF_FFFC) | 32'(vecs[i].off);
            send(5'(10 + i), 1'b1, 2'b01, vecs[i].f3, tmp, 32'h0);
            step();
            idle();
            low = 0;
            for (int c = 0; c < 4; c++) begin
                if (c == 3) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = vecs[i].word;
                end
                if (!bus.in_ready) low++;
                step();
            end
            idle();
            exp_instret++;
            chk($sformatf("C%0d_ready_low", i), 32'(low), 32'd4);
            chk($sformatf("C%0d_we", i), 32'(rf_we3), 32'd1);
            chk($sformatf("C%0d_a3", i), 32'(rf_a3), 32'(10 + i));
            chk($sformatf("C%0d_wd3", i), rf_wd3, vecs[i].exp);
            step();
        end
        chk("C_instret", instret, 32'(exp_instret));

        // rd == 0 and reg_write == 0 retire without writing
        send(5'd0, 1'b1, 2'b00, 3'b000, 32'hDEADBEEF, 32'h0);
        step();
        idle();
        exp_instret++;
        chk("D_rd0_we", 32'(rf_we3), 32'd0);
        chk("D_rd0_instret", instret, 32'(exp_instret));
        send(5'd7, 1'b0, 2'b10, 3'b000, 32'h1, 32'h2);
        step();
        idle();
        exp_instret++;
        chk("D_nrw_we", 32'(rf_we3), 32'd0);
        chk("D_nrw_instret", instret, 32'(exp_instret));

        // Stray response in IDLE, flag stays sticky
        chk("E_err_before", 32'(rsp_err), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BADF00D;
        step();
        idle();
        chk("E_err_rise", 32'(rsp_err), 32'd1);
        send(5'd4, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0);
        step();
        idle();
        chk("E_we", 32'(rf_we3), 32'd1);
        chk("E_wd3", rf_wd3, 32'h55);
        chk("E_err_hold", 32'(rsp_err), 32'd1);
        step();
        chk("E_err_hold2", 32'(rsp_err), 32'd1);

        // Response in the accept cycle of a load is an error
        do_reset();
        send(5'd6, 1'b1, 2'b01, 3'b010, 32'h0, 32'h0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hAAAA5555;
        step();
        idle();
        chk("F_err", 32'(rsp_err), 32'd1);
        chk("F_ready", 32'(bus.in_ready), 32'd0);
        chk("F_we0", 32'(rf_we3), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h13572468;
        step();
        idle();
        chk("F_we1", 32'(rf_we3), 32'd1);
        chk("F_a3", 32'(rf_a3), 32'd6);
        chk("F_wd3", rf_wd3, 32'h13572468);
        step();

        // Random instruction stream against the reference model
        do_reset();
        expq.delete();
        issued = 0;
        cyc    = 0;
        pend   = 1'b0;
        wait_c = 0;
        while ((issued < 1000 || pend || expq.size() != 0) && cyc < 20000) begin
            if (rf_we3) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL R_spurious_write: got write rd=%0d data=0x%08h expected none",
                             rf_a3, rf_wd3);
                end else begin
                    w = expq.pop_front();
                    chk("R_a3", 32'(rf_a3), 32'(w.rd));
                    chk("R_wd3", rf_wd3, w.data);
                    chk("R_fwd", fwd_data, w.data);
                end
            end
            chk("R_ready", 32'(bus.in_ready), 32'(!pend));
            idle();
            r_rd  = 5'($urandom_range(0, 31));
            r_rw  = ($urandom_range(0, 7) != 0);
            r_src = 2'($urandom_range(0, 3));
            r_f3  = 3'($urandom_range(0, 7));
            r_alu = $urandom();
            r_pc  = $urandom();
            if (pend) begin
                if ($urandom_range(0, 1) == 1) send(r_rd, r_rw, r_src, r_f3, r_alu, r_pc);
                if (wait_c == 0) begin
                    r_word        = $urandom();
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = r_word;
                    expq.push_back('{prd, ref_ext(r_word, pf3, poff)});
                    pend = 1'b0;
                end else begin
                    wait_c--;
                end
            end else if (issued < 1000 && $urandom_range(0, 3) != 0) begin
                send(r_rd, r_rw, r_src, r_f3, r_alu, r_pc);
                issued++;
                if (r_rw && r_rd != 5'd0) begin
                    if (r_src == 2'b01) begin
                        pend   = 1'b1;
                        prd    = r_rd;
                        pf3    = r_f3;
                        poff   = r_alu[1:0];
                        wait_c = $urandom_range(0, 3);
                    end else begin
                        expq.push_back('{r_rd, (r_src == 2'b10) ? r_pc : r_alu});
                    end
                end
            end
            step();
            cyc++;
        end
        idle();
        if (cyc >= 20000) begin
            n_cmp++;
            n_err++;
            $display("FAIL R_timeout: issued %0d pending writes %0d after %0d cycles",
                     issued, expq.size(), cyc);
        end
        step();
        chk("R_last_we", 32'(rf_we3), 32'd0);
        chk("R_instret", instret, 32'd1000);
        chk("R_err", 32'(rsp_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
